// File: rtl/spi_slv.sv
// Mode-3 (CPOL=1, CPHA=1) SPI responder for 16-bit frames, with all SPI pins
// oversampled in the clk domain. Good frames strobe rdy; bad bit counts strobe frm_err.
module spi_slv #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wrt_tx,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        frm_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, ss_hist_q;

  // Equal-depth chains keep the sampled MOSI aligned with its SCLK edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '1;
      sclk_hist_q <= 1'b1;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;

  state_t      state_q, state_d;
  logic [15:0] tx_buf_q, tx_buf_d;
  logic [15:0] tx_shift_q, tx_shift_d;
  logic [15:0] rx_shift_q, rx_shift_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        rdy_q, rdy_d, ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rdy_q      <= rdy_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = wrt_tx ? tx_data : tx_buf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rdy_d      = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_shift_d = tx_buf_q;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT, TAIL: begin
        if (sclk_rise) begin
          if (state_q == SHIFT) begin
            rx_shift_d = {rx_shift_q[14:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_d == 5'd16) state_d = TAIL;
          end else begin
            bit_cnt_d = 5'd17;
          end
        end
        // The leading fall (count 0) must not shift out tx_buf[15] before it is sampled.
        if (sclk_fall && state_q == SHIFT && bit_cnt_q != 5'd0)
          tx_shift_d = {tx_shift_q[14:0], 1'b0};
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_d == 5'd16) begin
            rx_data_d = rx_shift_d;
            rdy_d     = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO    = SS_n ? 1'bz : tx_shift_q[15];
  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = ferr_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: doc/spi_slv.md
# spi_slv

Mode-3 SPI responder (CPOL=1, CPHA=1) for 16-bit frames. It is the target end of the serial link driven by our 16-bit SPI master, and lets on-chip logic act as an SPI peripheral (sensor model, debug port). All SPI inputs are asynchronous and are oversampled in the clk domain. Completed frames are delivered with a one-cycle `rdy` strobe, and the reply word is supplied through a load strobe.

## Interface
- `SYNC_STAGES`, default 2: metastability flops per SPI input. Must be 2 or more. The edge-detect flop is additional.
- `clk` in, 1: system clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `SCLK` in, 1: serial clock, asynchronous, idles high.
- `SS_n` in, 1: active-low frame select, asynchronous.
- `MOSI` in, 1: master data. The master changes it on SCLK falls; this block samples it on SCLK rises.
- `MISO` out, 1: reply data. Equals `tx_shift[15]` while raw `SS_n`=0, else 1'bz.
- `wrt_tx` in, 1: load `tx_data` into the reply buffer.
- `tx_data` in, 16: reply word.
- `rx_data` out, 16: last good received word, MSB first.
- `rdy` out, 1: one-clk pulse when a good frame completes.
- `frm_err` out, 1: one-clk pulse when a frame ends with a bit count other than 16.
- `busy` out, 1: high while a frame is in progress.

## Operation
- **Synchronizers.** `SCLK`, `SS_n` and `MOSI` each pass through `SYNC_STAGES` flops plus one history flop. All three have the same depth, so a sampled `MOSI` is aligned with its `SCLK` edge.
  - All sync flops reset to 1.
  - Rise = sync & ~hist. Fall = ~sync & hist.
- **Registers.**
  - `tx_buf`: 16 bits, reset 0. Written on `wrt_tx` in any state. The value persists and is reused by later frames until rewritten.
  - `tx_shift`, `rx_shift`: 16 bits each.
  - `bit_cnt`: 5 bits, saturates at 17.
  - `rx_data`: reset 0. Updated only on a good frame.
- **FSM:** IDLE, SHIFT, TAIL.
  - **IDLE:** on SS_n fall, load `tx_shift`←`tx_buf`, clear `bit_cnt` and `rx_shift`, go to SHIFT.
  - **SHIFT:**
    - SCLK rise: `rx_shift`←{`rx_shift[14:0]`, MOSI_sync}; `bit_cnt`+1. If the new count is 16, go to TAIL.
    - SCLK fall with `bit_cnt`≥1: `tx_shift`←{`tx_shift[14:0]`,0}.
    - SCLK fall with `bit_cnt`=0 is the leading fall and is ignored.
    - SS_n rise: pulse `frm_err`, go to IDLE.
  - **TAIL:**
    - SCLK rise: `bit_cnt`→17 (error marked).
    - SCLK fall: no shift.
    - SS_n rise with `bit_cnt`=16: `rx_data`←`rx_shift`, pulse `rdy`, go to IDLE.
    - SS_n rise with `bit_cnt`=17: pulse `frm_err`, `rx_data` unchanged, go to IDLE.
- **Simultaneous events.** SS_n rise and SCLK rise in the same cycle: process the SCLK rise first, then evaluate the end of frame with the updated count. SS_n fall while not in IDLE cannot occur without an intervening rise; it is ignored.
- **`wrt_tx` during a frame** updates `tx_buf` only. The current `tx_shift` is untouched, and the new word is sent on the next frame.
- **`busy`** = (state≠IDLE).
- **Reset mid-frame** clears everything. Because the sync flops reset to 1, a low `SS_n` at reset release is seen as a fall and a partial frame starts. That frame ends with `frm_err`, never `rdy`.

## Timing
- **Reset values:** `rdy`=0, `frm_err`=0, `busy`=0, `rx_data`=0, `tx_buf`=0, state IDLE. `MISO`=z while `SS_n`=1.
- **Edge detection latency:** SYNC_STAGES+1 clk edges after the raw pin edge. With the default, that is 3 edges, with a ±1 edge sampling-phase window.
- **`rdy`/`frm_err`:** registered, asserted on the edge after detection (4±1 clk after raw `SS_n` rises), high exactly 1 clk.
- **`MISO` after a fall:** `MISO` presents the next bit within 4 clk of a raw SCLK fall. The first bit (`tx_buf[15]`) is valid within 4 clk of `SS_n` falling.
- **Input requirements:**
  - SCLK high and low phases ≥ 6 clk each.
  - `SS_n` fall to first SCLK fall ≥ 6 clk.
  - Last SCLK rise to `SS_n` rise ≥ 6 clk.
  - `SS_n` high time ≥ 6 clk.
  - The standard master (SCLK period 32 clk) meets all of these.
- **Back-to-back frames** separated by the minimum `SS_n` high time each produce their own `rdy`.

## Test plan
- **Basic exchange.** Reset; `wrt_tx` with `tx_data`=16'hA5C3; master sends 16'h8F00 at SCLK period 32 clk. Required: master reads 16'hA5C3; `rx_data`=16'h8F00; `rdy` high 1 clk; `frm_err` never asserted; `busy` falls with `rdy`.
- **Back-to-back with buffer update.** Two frames with `SS_n` high 16 clk between; `wrt_tx` 16'h1234 during frame 1 (`tx_buf` was 16'hFFFF). Required: frame 1 returns 16'hFFFF, frame 2 returns 16'h1234; two `rdy` pulses; `rx_data` matches each command.
- **Short frame.** `SS_n` raised after 8 rises. Required: `frm_err` 1 clk, no `rdy`, `rx_data` holds its prior value; the next full frame succeeds.
- **Long frame.** 17 SCLK rises within one `SS_n` low. Required: `frm_err` pulse, no `rdy`, `rx_data` unchanged.
- **Reset mid-frame.** Assert `rst_n` after 5 rises, release with `SS_n` low, finish the frame. Required: all outputs at reset values during reset; `frm_err` at `SS_n` rise; the following full frame gives `rdy` and the correct data with `tx_buf`=0.
- **Minimum timing.** SCLK phases 6 clk, `SS_n` gaps 6 clk, random 16-bit words over 200 frames. Required: every frame `rdy`, exact `rx_data` and master-received `MISO` match.
